// File: rtl/sdram_user_pkg.sv
// Shared definitions for the SDRAM user-port traffic generator and its bench:
// port widths, the generator's state encoding and the per-address test pattern.
package sdram_user_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    WR_ISSUE,
    WR_GAP,
    RD_ISSUE,
    RD_WAIT,
    FAIL
  } state_t;

  // Low half is the address, high half its complement against A5A5, so stuck
  // or swapped data lines show up as a mismatch on at least one word.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

endpackage

// File: rtl/sdram_ram_test_if.sv
// User-port bundle between the RAM test generator (master) and the SDRAM controller (slave).
interface sdram_ram_test_if #(
  parameter int ADDR_W = sdram_user_pkg::ADDR_W,
  parameter int DATA_W = sdram_user_pkg::DATA_W
);

  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              in_valid;
  logic              out_valid;

  // Handshake: a command (addr/rw/data_in) is taken on the posedge where
  // in_valid=1 and busy=0; in_valid is a one-cycle strobe and the command
  // fields are stable while it is high. out_valid is a one-cycle strobe
  // qualifying data_out for the single outstanding read.
  modport master (
    output addr, rw, data_in, in_valid,
    input  data_out, busy, out_valid
  );

  modport slave (
    input  addr, rw, data_in, in_valid,
    output data_out, busy, out_valid
  );

endinterface

// File: rtl/sdram_ram_test.sv
// Write/read-back pattern tester for the SDRAM user port. Loops forever counting
// clean passes on leds; freezes with the failing index on the first bad word.
module sdram_ram_test
  import sdram_user_pkg::*;
#(
  parameter int ADDR_W    = sdram_user_pkg::ADDR_W,
  parameter int DATA_W    = sdram_user_pkg::DATA_W,
  parameter int NUM_WORDS = 64
) (
  input  logic             clk,
  input  logic             rst,
  sdram_ram_test_if.master user,
  output logic [7:0]       leds,
  output state_t           dbg_state
);

  localparam int IDX_W = $clog2(NUM_WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [6:0]        pass_q, pass_d;
  logic [6:0]        fail_idx_q, fail_idx_d;
  logic              in_valid_q, in_valid_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [31:0]       idx_ext;
  logic [DATA_W-1:0] pat_cur;
  logic              last;

  assign idx_ext = 32'(idx_q);
  assign pat_cur = DATA_W'(pat(idx_ext));
  assign last    = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WR_ISSUE;
      idx_q      <= '0;
      pass_q     <= '0;
      fail_idx_q <= '0;
      in_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      in_valid_q <= in_valid_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // The strobe is registered, so the ISSUE->GAP/WAIT transition is the strobe
  // cycle; busy is sampled again only after the controller has had a cycle to raise it.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    in_valid_d = 1'b0;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      WR_ISSUE: begin
        if (!user.busy) begin
          in_valid_d = 1'b1;
          rw_d       = 1'b1;
          addr_d     = ADDR_W'(idx_q);
          data_d     = pat_cur;
          state_d    = WR_GAP;
        end
      end
      WR_GAP: begin
        if (last) begin
          idx_d   = '0;
          state_d = RD_ISSUE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = WR_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (!user.busy) begin
          in_valid_d = 1'b1;
          rw_d       = 1'b0;
          addr_d     = ADDR_W'(idx_q);
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (user.out_valid) begin
          if (user.data_out == pat_cur) begin
            if (last) begin
              idx_d   = '0;
              pass_d  = pass_q + 7'd1;
              state_d = WR_ISSUE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = RD_ISSUE;
            end
          end else begin
            fail_idx_d = idx_ext[6:0];
            state_d    = FAIL;
          end
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = WR_ISSUE;
    endcase
  end

  assign user.in_valid = in_valid_q;
  assign user.rw       = rw_q;
  assign user.addr     = addr_q;
  assign user.data_in  = data_q;

  assign leds      = (state_q == FAIL) ? {1'b1, fail_idx_q} : {1'b0, pass_q};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_ram_test.sv
// Bench for sdram_ram_test: behavioural user-port controller with a word memory,
// an expected-command queue built pass by pass, and per-cycle leds/protocol checks.
module tb_sdram_ram_test;
  import sdram_user_pkg::*;

  localparam int NW = 4;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int CW = 1 + AW + DW;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] leds;
  state_t     dbg_state;

  always #5 clk = ~clk;

  sdram_ram_test_if #(.ADDR_W(AW), .DATA_W(DW)) user ();

  sdram_ram_test #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .user      (user),
    .leds      (leds),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] cmd_log[$];
  logic [DW-1:0] mem[64];

  int         passes = 0;
  bit         failed = 0;
  logic [6:0] fail_idx_m = '0;
  int         iv_pulses = 0;

  bit          force_busy = 0;
  bit          inject = 0;
  int          corrupt_addr = -1;
  int          bmin = 3, bmax = 3, lmin = 4, lmax = 4;
  int          busy_cnt = 0, rd_cnt = 0;
  bit          acc_prev = 0, rd_pending = 0, delivered = 0, prev_in_valid = 0;
  logic [AW-1:0] rd_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_cmd(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {rw, a, (rw ? d : {DW{1'b0}})};
  endfunction

  // One pass as the spec describes it: write every word, then read every word.
  task automatic fill_pass();
    for (int i = 0; i < NW; i++) exp_q.push_back(mk_cmd(1'b1, AW'(i), pat(32'(i))));
    for (int i = 0; i < NW; i++) exp_q.push_back(mk_cmd(1'b0, AW'(i), '0));
  endtask

  // ---------------- controller model + compare process ----------------
  always @(negedge clk) begin
    logic [7:0]    exp_leds;
    logic [CW-1:0] act, exp;
    bit            acc_now;
    acc_now = 0;
    if (!rst) begin
      check("rst_leds", 64'(leds), 64'h00);
      check("rst_in_valid", 64'(user.in_valid), 64'h0);
      exp_q.delete();
      passes = 0; failed = 0; busy_cnt = 0; rd_cnt = 0;
      acc_prev = 0; rd_pending = 0; delivered = 0; prev_in_valid = 0;
      user.busy = force_busy;
      user.out_valid = 1'b0;
    end else begin
      // Read data delivered last cycle was consumed at the posedge just passed.
      if (delivered) begin
        delivered = 0;
        if (user.data_out == pat(32'(rd_addr))) begin
          if (int'(rd_addr) == NW - 1) passes++;
        end else begin
          failed = 1;
          fail_idx_m = rd_addr[6:0];
        end
      end
      exp_leds = failed ? {1'b1, fail_idx_m} : {1'b0, passes[6:0]};
      check("leds", 64'(leds), 64'(exp_leds));

      if (user.in_valid) begin
        iv_pulses++;
        check("iv_while_busy", 64'(user.busy), 64'h0);
        check("iv_width", 64'(prev_in_valid), 64'h0);
        check("iv_after_fail", 64'(failed), 64'h0);
        if (!user.busy) begin
          act = mk_cmd(user.rw, user.addr, user.data_in);
          if (exp_q.size() == 0) fill_pass();
          exp = exp_q.pop_front();
          check("cmd", 64'(act), 64'(exp));
          cmd_log.push_back(act);
          if (user.rw) mem[user.addr[5:0]] = user.data_in;
          else begin
            rd_addr = user.addr;
            rd_cnt = $urandom_range(lmax, lmin) + 1;
            rd_pending = 1;
          end
          acc_now = 1;
        end
      end
      prev_in_valid = user.in_valid;

      user.out_valid = 1'b0;
      if (rd_pending) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          rd_pending = 0;
          delivered = 1;
          user.out_valid = 1'b1;
          user.data_out = mem[rd_addr[5:0]] ^ ((int'(rd_addr) == corrupt_addr) ? 32'h1 : 32'h0);
        end
      end
      if (inject) begin
        inject = 0;
        user.out_valid = 1'b1;
        user.data_out = $urandom;
      end
      if (busy_cnt > 0) busy_cnt--;
      if (acc_prev) busy_cnt = $urandom_range(bmax, bmin);
      acc_prev = acc_now;
      user.busy = force_busy || (busy_cnt > 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    step(1);
    rst = 1'b0;
    step(2);
    cmd_log.delete();
    rst = 1'b1;
  endtask

  task automatic wait_passes(input string name, input int n, input int budget);
    int c = 0;
    while (passes < n && c < budget) begin
      step(1);
      c++;
    end
    check(name, 64'(passes), 64'(n));
  endtask

  task automatic wait_cmds(input string name, input int n, input int budget);
    int c = 0;
    while (cmd_log.size() < n && c < budget) begin
      step(1);
      c++;
    end
    check(name, 64'(cmd_log.size() >= n), 64'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int iv0;
    int c;
    user.busy = 1'b0;
    user.out_valid = 1'b0;
    user.data_out = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    step(3);
    check("reset_in_valid", 64'(user.in_valid), 64'h0);
    check("reset_addr", 64'(user.addr), 64'h0);
    check("reset_rw", 64'(user.rw), 64'h0);
    check("reset_data_in", 64'(user.data_in), 64'h0);
    check("reset_leds", 64'(leds), 64'h00);
    rst = 1'b1;

    // Two clean passes with the fixed-latency controller.
    wait_passes("pass1_reached", 1, 2000);
    check("leds_pass1", 64'(leds), 64'h01);
    wait_passes("pass2_reached", 2, 2000);
    check("leds_pass2", 64'(leds), 64'h02);
    check("wr0", 64'(cmd_log[0]), 64'(mk_cmd(1'b1, 0, 32'hA5A50000)));
    check("wr1", 64'(cmd_log[1]), 64'(mk_cmd(1'b1, 1, 32'hA5A40001)));
    check("wr2", 64'(cmd_log[2]), 64'(mk_cmd(1'b1, 2, 32'hA5A70002)));
    check("wr3", 64'(cmd_log[3]), 64'(mk_cmd(1'b1, 3, 32'hA5A60003)));
    for (int i = 0; i < NW; i++)
      check("rd_order", 64'(cmd_log[NW + i]), 64'(mk_cmd(1'b0, AW'(i), '0)));

    // Busy held high for 50 cycles out of reset.
    force_busy = 1;
    do_reset();
    iv0 = iv_pulses;
    step(50);
    check("busy_hold_no_cmd", 64'(iv_pulses - iv0), 64'h0);
    force_busy = 0;
    step(1);
    check("busy_released_idle", 64'(user.in_valid), 64'h0);
    step(1);
    check("first_wr_after_busy", 64'(user.in_valid), 64'h1);
    check("first_wr_cmd", 64'({user.rw, user.addr, user.data_in}), 64'(mk_cmd(1'b1, 0, 32'hA5A50000)));

    // Corrupted read of word 2 must freeze the tester.
    corrupt_addr = 2;
    do_reset();
    c = 0;
    while (!failed && c < 2000) begin
      step(1);
      c++;
    end
    check("fail_reached", 64'(failed), 64'h1);
    check("leds_fail", 64'(leds), 64'h82);
    iv0 = iv_pulses;
    step(1000);
    check("fail_no_cmd", 64'(iv_pulses - iv0), 64'h0);
    check("leds_fail_hold", 64'(leds), 64'h82);
    corrupt_addr = -1;

    // Reset while a read is outstanding, then a stray out_valid after release.
    do_reset();
    wait_cmds("first_read_issued", NW + 1, 2000);
    step(2);
    check("in_rd_wait", 64'(dbg_state), 64'(RD_WAIT));
    rst = 1'b0;
    step(2);
    cmd_log.delete();
    rst = 1'b1;
    step(2);
    inject = 1;
    wait_cmds("cmd_after_abort", 1, 200);
    check("abort_first_cmd", 64'(cmd_log[0]), 64'(mk_cmd(1'b1, 0, 32'hA5A50000)));
    step(5);
    check("abort_leds", 64'(leds), 64'h00);
    wait_cmds("cmd2_after_abort", 2, 200);
    check("abort_second_cmd", 64'(cmd_log[1]), 64'(mk_cmd(1'b1, 1, 32'hA5A40001)));

    // Long randomized run: pass counter must wrap at 128.
    bmin = 1; bmax = 4; lmin = 2; lmax = 6;
    do_reset();
    wait_passes("pass127_reached", 127, 20000);
    check("leds_pass127", 64'(leds), 64'h7F);
    wait_passes("pass128_reached", 128, 2000);
    check("leds_wrap", 64'(leds), 64'h00);
    wait_passes("pass129_reached", 129, 2000);
    check("leds_after_wrap", 64'(leds), 64'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
